// File: rtl/risc16_dmem_arbiter_pkg.sv
// risc16_dmem_arbiter_pkg
//   Shared definitions for the RISC16 data-memory arbiter and the requesters
//   attached to it (cpu core, debug loader).
//   - ADDR_W_DEF / DATA_W_DEF / MAX_WAIT_DEF : default bus geometry and starvation limit
//   - REQ_C / REQ_D                           : requester ids carried with a read response
//   - cnt_width()                             : width of a counter that must reach max_wait
package risc16_dmem_arbiter_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int MAX_WAIT_DEF = 4;

  localparam logic REQ_C = 1'b0;
  localparam logic REQ_D = 1'b1;

  // A limit of 0 still needs one flop so the counter has a legal width.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/risc16_dmem_arbiter_if.sv
// risc16_dmem_arbiter_if
//   One requester's access channel to the shared data memory.
//   master modport: requester side (drives req/we/addr/wdata, receives gnt/rvalid/rdata)
//   slave modport : arbiter side
//   req/we/addr/wdata are held stable by the requester until gnt=1; the transfer
//   happens in the cycle where req & gnt. rvalid/rdata return one cycle after a read grant.
interface risc16_dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/risc16_dmem_arbiter_starve_cnt.sv
// risc16_dmem_arbiter_starve_cnt
//   Saturating count of consecutive cycles the debug port has been denied.
//   Ports:
//     clk, rst_n : system clock, asynchronous active-low reset
//     inc_i      : D requested and was not granted this cycle
//     clr_i      : D granted or not requesting this cycle (wins over inc_i)
//     at_max_o   : count has reached MAX_WAIT, D must win the next conflict
module risc16_dmem_arbiter_starve_cnt
  import risc16_dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int CNT_W = cnt_width(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // With MAX_WAIT=0 the count never leaves 0, so at_max is permanently set and
  // the debug port effectively has priority.
  assign at_max_o = (cnt_q == CNT_W'(MAX_WAIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/risc16_dmem_arbiter.sv
// risc16_dmem_arbiter
//   Shares the single-port 256x16 RISC16 data RAM between the CPU (port C) and the
//   debug/loader (port D). C has fixed priority; D is forced through after it has
//   been denied MAX_WAIT consecutive cycles.
//   Ports:
//     clk, rst_n   : system clock, asynchronous active-low reset
//     c_if, d_if   : requester channels (slave side)
//     mem_en_o     : RAM access strobe
//     mem_we_o     : RAM write enable
//     mem_addr_o   : RAM word address (passed through unchanged)
//     mem_wdata_o  : RAM write data
//     mem_rdata_i  : RAM read data, valid one cycle after a read strobe
module risc16_dmem_arbiter
  import risc16_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  risc16_dmem_arbiter_if.slave c_if,
  risc16_dmem_arbiter_if.slave d_if,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic [DATA_W-1:0]    mem_rdata_i
);

  logic              at_max;
  logic              d_win;
  logic              c_win;
  logic              c_gnt;
  logic              d_gnt;
  logic              c_rvalid;
  logic              d_rvalid;

  logic              resp_pend_q;
  logic              resp_pend_d;
  logic              resp_id_q;
  logic              resp_id_d;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] d_rdata_d;

  risc16_dmem_arbiter_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (d_if.req & ~d_gnt),
    .clr_i    (~d_if.req | d_gnt),
    .at_max_o (at_max)
  );

  // Grants are gated by rst_n so nothing reaches the RAM while reset is asserted,
  // even though the requests themselves are combinational inputs.
  always_comb begin
    d_win = d_if.req & (~c_if.req | at_max);
    c_win = c_if.req & ~d_win;
    c_gnt = c_win & rst_n;
    d_gnt = d_win & rst_n;
  end

  assign c_if.gnt = c_gnt;
  assign d_if.gnt = d_gnt;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (d_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = d_if.we;
      mem_addr_o  = d_if.addr;
      mem_wdata_o = d_if.wdata;
    end else if (c_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = c_if.we;
      mem_addr_o  = c_if.addr;
      mem_wdata_o = c_if.wdata;
    end
  end

  // The requester id is latched at grant time, so a response always returns to the
  // port that issued the read even if the other port wins the same cycle it lands.
  always_comb begin
    resp_pend_d = mem_en_o & ~mem_we_o;
    resp_id_d   = resp_id_q;
    if (resp_pend_d) begin
      resp_id_d = d_gnt ? REQ_D : REQ_C;
    end
  end

  assign c_rvalid = resp_pend_q & (resp_id_q == REQ_C);
  assign d_rvalid = resp_pend_q & (resp_id_q == REQ_D);

  // Read data is forwarded from the RAM in the response cycle and held afterwards.
  always_comb begin
    c_rdata_d = c_rvalid ? mem_rdata_i : c_rdata_q;
    d_rdata_d = d_rvalid ? mem_rdata_i : d_rdata_q;
  end

  assign c_if.rvalid = c_rvalid;
  assign d_if.rvalid = d_rvalid;
  assign c_if.rdata  = c_rdata_d;
  assign d_if.rdata  = d_rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_pend_q <= 1'b0;
      resp_id_q   <= REQ_C;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      resp_pend_q <= resp_pend_d;
      resp_id_q   <= resp_id_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_risc16_dmem_arbiter.sv
// tb_risc16_dmem_arbiter
//   Directed scenarios plus a constrained random phase for the data-memory arbiter,
//   with a behavioural single-port RAM attached to the mem_* side.
module tb_risc16_dmem_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ram [0:255];

  int pass_cnt = 0;
  int total_cnt = 0;

  risc16_dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c_bus ();
  risc16_dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) d_bus ();

  risc16_dmem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .c_if        (c_bus),
    .d_if        (d_bus),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_all();
    c_bus.req = 1'b0; c_bus.we = 1'b0; c_bus.addr = '0; c_bus.wdata = '0;
    d_bus.req = 1'b0; d_bus.we = 1'b0; d_bus.addr = '0; d_bus.wdata = '0;
  endtask

  task automatic drain();
    @(negedge clk);
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    c_bus.req = 1'b1;
    d_bus.req = 1'b1;
    @(negedge clk); #1;
    total_cnt++; if (c_bus.gnt !== 1'b0) $display("FAIL rst_c_gnt: got %b want 0", c_bus.gnt); else pass_cnt++;
    total_cnt++; if (d_bus.gnt !== 1'b0) $display("FAIL rst_d_gnt: got %b want 0", d_bus.gnt); else pass_cnt++;
    total_cnt++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en: got %b want 0", mem_en); else pass_cnt++;
    total_cnt++; if (c_bus.rvalid !== 1'b0 || d_bus.rvalid !== 1'b0)
      $display("FAIL rst_rvalid: got c=%b d=%b want 0 0", c_bus.rvalid, d_bus.rvalid); else pass_cnt++;
    total_cnt++; if (c_bus.rdata !== 16'h0 || d_bus.rdata !== 16'h0)
      $display("FAIL rst_rdata: got c=%h d=%h want 0000 0000", c_bus.rdata, d_bus.rdata); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (c_bus.gnt !== 1'b1 || d_bus.gnt !== 1'b0)
      $display("FAIL rel_first_gnt: got c=%b d=%b want 1 0", c_bus.gnt, d_bus.gnt); else pass_cnt++;
    idle_all();
    @(negedge clk); #1;
    total_cnt++; if (c_bus.rvalid !== 1'b0) $display("FAIL rel_no_resp: got %b want 0", c_bus.rvalid); else pass_cnt++;
  endtask

  task automatic test_c_write_read();
    @(negedge clk);
    idle_all();
    c_bus.req = 1'b1; c_bus.we = 1'b1; c_bus.addr = 8'h10; c_bus.wdata = 16'h1234;
    #1;
    total_cnt++; if (c_bus.gnt !== 1'b1) $display("FAIL wr_gnt: got %b want 1", c_bus.gnt); else pass_cnt++;
    total_cnt++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h10, 16'h1234})
      $display("FAIL wr_mem: got en=%b we=%b a=%h d=%h want 1 1 10 1234", mem_en, mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    @(negedge clk);
    c_bus.we = 1'b0;
    #1;
    total_cnt++; if (c_bus.gnt !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL rd_gnt: got gnt=%b we=%b want 1 0", c_bus.gnt, mem_we); else pass_cnt++;
    total_cnt++; if (c_bus.rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b want 0", c_bus.rvalid); else pass_cnt++;
    @(negedge clk);
    idle_all();
    #1;
    total_cnt++; if (c_bus.rvalid !== 1'b1 || c_bus.rdata !== 16'h1234)
      $display("FAIL rd_resp: got v=%b d=%h want 1 1234", c_bus.rvalid, c_bus.rdata); else pass_cnt++;
    total_cnt++; if (d_bus.rvalid !== 1'b0) $display("FAIL rd_resp_d: got %b want 0", d_bus.rvalid); else pass_cnt++;
    total_cnt++; if (mem_en !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 16'h0)
      $display("FAIL idle_mem: got en=%b a=%h d=%h want 0 00 0000", mem_en, mem_addr, mem_wdata); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (c_bus.rvalid !== 1'b0 || c_bus.rdata !== 16'h1234)
      $display("FAIL rd_hold: got v=%b d=%h want 0 1234", c_bus.rvalid, c_bus.rdata); else pass_cnt++;
  endtask

  task automatic test_starvation();
    logic exp_d;
    int   exp_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      c_bus.req = 1'b1; c_bus.we = 1'b0; c_bus.addr = 8'h30;
      d_bus.req = 1'b1; d_bus.we = 1'b0; d_bus.addr = 8'h31;
      #1;
      exp_d   = (i == 4);
      exp_cnt = (i <= 4) ? i : 0;
      total_cnt++; if (c_bus.gnt !== ~exp_d || d_bus.gnt !== exp_d)
        $display("FAIL starve_gnt[%0d]: got c=%b d=%b want %b %b", i, c_bus.gnt, d_bus.gnt, ~exp_d, exp_d);
      else pass_cnt++;
      total_cnt++; if (int'(dut.u_starve.cnt_q) != exp_cnt)
        $display("FAIL starve_cnt[%0d]: got %0d want %0d", i, dut.u_starve.cnt_q, exp_cnt); else pass_cnt++;
      total_cnt++; if (mem_addr !== (exp_d ? 8'h31 : 8'h30))
        $display("FAIL starve_addr[%0d]: got %h want %h", i, mem_addr, exp_d ? 8'h31 : 8'h30); else pass_cnt++;
    end
    drain();
  endtask

  task automatic test_pipeline();
    @(negedge clk);
    idle_all();
    d_bus.req = 1'b1; d_bus.we = 1'b1; d_bus.addr = 8'h20; d_bus.wdata = 16'hBEEF;
    #1;
    total_cnt++; if (d_bus.gnt !== 1'b1) $display("FAIL pre_wr0: got %b want 1", d_bus.gnt); else pass_cnt++;
    @(negedge clk);
    d_bus.addr = 8'h21; d_bus.wdata = 16'hCAFE;
    #1;
    total_cnt++; if (d_bus.gnt !== 1'b1) $display("FAIL pre_wr1: got %b want 1", d_bus.gnt); else pass_cnt++;
    @(negedge clk);
    d_bus.we = 1'b0; d_bus.addr = 8'h20;
    #1;
    total_cnt++; if (d_bus.gnt !== 1'b1) $display("FAIL pipe_d_gnt: got %b want 1", d_bus.gnt); else pass_cnt++;
    @(negedge clk);
    idle_all();
    c_bus.req = 1'b1; c_bus.we = 1'b0; c_bus.addr = 8'h21;
    #1;
    total_cnt++; if (c_bus.gnt !== 1'b1) $display("FAIL pipe_c_gnt: got %b want 1", c_bus.gnt); else pass_cnt++;
    total_cnt++; if (d_bus.rvalid !== 1'b1 || d_bus.rdata !== 16'hBEEF || c_bus.rvalid !== 1'b0)
      $display("FAIL pipe_d_resp: got dv=%b dd=%h cv=%b want 1 beef 0", d_bus.rvalid, d_bus.rdata, c_bus.rvalid);
    else pass_cnt++;
    @(negedge clk);
    idle_all();
    #1;
    total_cnt++; if (c_bus.rvalid !== 1'b1 || c_bus.rdata !== 16'hCAFE || d_bus.rvalid !== 1'b0)
      $display("FAIL pipe_c_resp: got cv=%b cd=%h dv=%b want 1 cafe 0", c_bus.rvalid, c_bus.rdata, d_bus.rvalid);
    else pass_cnt++;
    total_cnt++; if (d_bus.rdata !== 16'hBEEF) $display("FAIL pipe_d_hold: got %h want beef", d_bus.rdata); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle_all();
    c_bus.req = 1'b1; c_bus.we = 1'b0; c_bus.addr = 8'h21;
    #1;
    total_cnt++; if (c_bus.gnt !== 1'b1) $display("FAIL b2b_gnt0: got %b want 1", c_bus.gnt); else pass_cnt++;
    @(negedge clk);
    c_bus.addr = 8'h20;
    #1;
    total_cnt++; if (c_bus.gnt !== 1'b1 || c_bus.rvalid !== 1'b1 || c_bus.rdata !== 16'hCAFE)
      $display("FAIL b2b_resp0: got g=%b v=%b d=%h want 1 1 cafe", c_bus.gnt, c_bus.rvalid, c_bus.rdata);
    else pass_cnt++;
    @(negedge clk);
    idle_all();
    #1;
    total_cnt++; if (c_bus.rvalid !== 1'b1 || c_bus.rdata !== 16'hBEEF)
      $display("FAIL b2b_resp1: got v=%b d=%h want 1 beef", c_bus.rvalid, c_bus.rdata); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (c_bus.rvalid !== 1'b0 || c_bus.rdata !== 16'hBEEF)
      $display("FAIL b2b_hold: got v=%b d=%h want 0 beef", c_bus.rvalid, c_bus.rdata); else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    idle_all();
    d_bus.req = 1'b1; d_bus.we = 1'b0; d_bus.addr = 8'h20;
    #1;
    total_cnt++; if (d_bus.gnt !== 1'b1) $display("FAIL mid_gnt: got %b want 1", d_bus.gnt); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (d_bus.rvalid !== 1'b1) $display("FAIL mid_pending: got %b want 1", d_bus.rvalid); else pass_cnt++;
    rst_n = 1'b0;
    idle_all();
    #1;
    total_cnt++; if (d_bus.rvalid !== 1'b0 || d_bus.rdata !== 16'h0)
      $display("FAIL mid_in_rst: got v=%b d=%h want 0 0000", d_bus.rvalid, d_bus.rdata); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (d_bus.rvalid !== 1'b0) $display("FAIL mid_release: got %b want 0", d_bus.rvalid); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (d_bus.rvalid !== 1'b0 || c_bus.rvalid !== 1'b0)
      $display("FAIL mid_after: got d=%b c=%b want 0 0", d_bus.rvalid, c_bus.rvalid); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] ref_mem [0:255];
    logic              c_pend = 1'b0;
    logic              d_pend = 1'b0;
    logic              exp_c;
    logic              exp_d;
    logic              resp_v = 1'b0;
    logic              resp_id = 1'b0;
    logic [DATA_W-1:0] resp_data = '0;
    int                wcnt = 0;
    for (int a = 0; a < 256; a++) ref_mem[a] = ram[a];
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (!c_pend && $urandom_range(0, 2) != 0) begin
        c_pend = 1'b1;
        c_bus.we = 1'($urandom_range(0, 1));
        c_bus.addr = 8'h40 + 8'($urandom_range(0, 7));
        c_bus.wdata = 16'($urandom);
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1'b1;
        d_bus.we = 1'($urandom_range(0, 1));
        d_bus.addr = 8'h40 + 8'($urandom_range(0, 7));
        d_bus.wdata = 16'($urandom);
      end
      c_bus.req = c_pend;
      d_bus.req = d_pend;
      #1;
      total_cnt++; if (c_bus.rvalid !== (resp_v && !resp_id) || d_bus.rvalid !== (resp_v && resp_id))
        $display("FAIL rnd_rvalid[%0d]: got c=%b d=%b want %b %b", cyc, c_bus.rvalid, d_bus.rvalid,
                 resp_v && !resp_id, resp_v && resp_id);
      else pass_cnt++;
      if (resp_v) begin
        total_cnt++; if ((resp_id ? d_bus.rdata : c_bus.rdata) !== resp_data)
          $display("FAIL rnd_rdata[%0d]: got %h want %h", cyc, resp_id ? d_bus.rdata : c_bus.rdata, resp_data);
        else pass_cnt++;
      end
      exp_d = d_pend && (!c_pend || wcnt == MAX_WAIT);
      exp_c = c_pend && !exp_d;
      total_cnt++; if (c_bus.gnt !== exp_c || d_bus.gnt !== exp_d)
        $display("FAIL rnd_gnt[%0d]: got c=%b d=%b want %b %b", cyc, c_bus.gnt, d_bus.gnt, exp_c, exp_d);
      else pass_cnt++;
      total_cnt++; if ((c_bus.gnt & d_bus.gnt) !== 1'b0)
        $display("FAIL rnd_onehot[%0d]: got both granted want at most one", cyc); else pass_cnt++;
      resp_v = 1'b0;
      if (exp_d) begin
        if (d_bus.we) ref_mem[d_bus.addr] = d_bus.wdata;
        else begin resp_v = 1'b1; resp_id = 1'b1; resp_data = ref_mem[d_bus.addr]; end
        d_pend = 1'b0;
      end else if (exp_c) begin
        if (c_bus.we) ref_mem[c_bus.addr] = c_bus.wdata;
        else begin resp_v = 1'b1; resp_id = 1'b0; resp_data = ref_mem[c_bus.addr]; end
        c_pend = 1'b0;
      end
      if (d_pend && !exp_d) wcnt = (wcnt == MAX_WAIT) ? wcnt : wcnt + 1;
      else wcnt = 0;
    end
    @(negedge clk);
    idle_all();
    #1;
    total_cnt++; if (c_bus.rvalid !== (resp_v && !resp_id) || d_bus.rvalid !== (resp_v && resp_id))
      $display("FAIL rnd_last_rvalid: got c=%b d=%b want %b %b", c_bus.rvalid, d_bus.rvalid,
               resp_v && !resp_id, resp_v && resp_id);
    else pass_cnt++;
    if (resp_v) begin
      total_cnt++; if ((resp_id ? d_bus.rdata : c_bus.rdata) !== resp_data)
        $display("FAIL rnd_last_rdata: got %h want %h", resp_id ? d_bus.rdata : c_bus.rdata, resp_data);
      else pass_cnt++;
    end
    drain();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_c_write_read();
    test_starvation();
    test_pipeline();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
